// File: rtl/apb_arb_master.sv
// apb_arb_master: round-robin arbiter that funnels NREQ local requesters onto a
// single APB bus, runs the SETUP/ACCESS handshake and hands read data / error
// status back to the granted requester. Every wait on pready is bounded.
module apb_arb_master #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic [ADDR_W-1:0]        paddr,
    output logic                     pselx,
    output logic                     penable,
    output logic                     pwrite,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [NREQ-1:0]     gnt_d, done_d;
    logic [DATA_W-1:0]   rdata_d, pwdata_d;
    logic                err_d, pselx_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0]   paddr_d;

    logic                pick_valid;
    logic [OW-1:0]       pick_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic                timed_out;

    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    // Round-robin pick: first pending requester scanning upward from last_owner+1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int j = 1; j <= NREQ; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_valid && req[i] && (((int'(last_q) + j) % NREQ) == i)) begin
                    pick_valid = 1'b1;
                    pick_idx   = i[OW-1:0];
                end
            end
        end
    end

    // Mux the chosen requester's address, data and direction out of the packed buses.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == i[OW-1:0]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    // State register plus the registered copies of every output; reset aborts any transfer.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            paddr   <= '0;
            pselx   <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            done    <= done_d;
            rdata   <= rdata_d;
            err     <= err_d;
            paddr   <= paddr_d;
            pselx   <= pselx_d;
            penable <= penable_d;
            pwrite  <= pwrite_d;
            pwdata  <= pwdata_d;
        end
    end

    // Next-state: SETUP is a single cycle, ACCESS ends on pready or on timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || timed_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and arbitration bookkeeping.
    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        done_d    = '0;
        rdata_d   = rdata;
        err_d     = err;
        paddr_d   = paddr;
        pselx_d   = pselx;
        penable_d = penable;
        pwrite_d  = pwrite;
        pwdata_d  = pwdata;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d   = pick_idx;
                    gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    paddr_d   = sel_addr;
                    pwdata_d  = sel_wdata;
                    pwrite_d  = sel_write;
                    pselx_d   = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready || timed_out) begin
                    pselx_d   = 1'b0;
                    penable_d = 1'b0;
                    gnt_d     = '0;
                    done_d    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                    last_d    = owner_q;
                    if (pready) begin
                        err_d = pslverr;
                        if (!pwrite) rdata_d = prdata;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                gnt_d     = '0;
                pselx_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed bench for apb_arb_master with hand-computed expectations
// for writes, wait states, slave error, timeout, mid-transfer reset and contention.
module tb_apb_arb_master;

    logic         pclk;
    logic         presetn;
    logic [1:0]   req;
    logic [1:0]   req_write;
    logic [15:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [31:0]  rdata;
    logic         err;
    logic [7:0]   paddr;
    logic         pselx;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    int vectors     = 0;
    int miscompares = 0;

    apb_arb_master #(
        .NREQ(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Free-running 10 ns bus clock.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge, where registered outputs have settled.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Drive the requester-side inputs for both requesters at once.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        req       = r;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    // One comparison: count it, and on a miss count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        presetn = 1'b0;
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        prdata  = 32'h0;
        pready  = 1'b0;
        pslverr = 1'b0;
        tick();
        tick();
        checkOutput("reset_gnt",     32'(gnt), 32'h0);
        checkOutput("reset_done",    32'(done), 32'h0);
        checkOutput("reset_pselx",   32'(pselx), 32'h0);
        checkOutput("reset_penable", 32'(penable), 32'h0);
        checkOutput("reset_paddr",   32'(paddr), 32'h0);
        checkOutput("reset_rdata",   rdata, 32'h0);
        checkOutput("reset_err",     32'(err), 32'h0);
        presetn = 1'b1;

        // Write by requester 0 with no wait states.
        applyStimulus(2'b01, 2'b01, 8'h10, 8'h00, 32'hA5A5_0001, 32'h0);
        pready = 1'b1;
        tick();
        checkOutput("wr_setup_gnt",     32'(gnt), 32'h1);
        checkOutput("wr_setup_pselx",   32'(pselx), 32'h1);
        checkOutput("wr_setup_penable", 32'(penable), 32'h0);
        checkOutput("wr_setup_paddr",   32'(paddr), 32'h10);
        checkOutput("wr_setup_pwrite",  32'(pwrite), 32'h1);
        checkOutput("wr_setup_pwdata",  pwdata, 32'hA5A5_0001);
        applyStimulus(2'b01, 2'b00, 8'hFF, 8'h00, 32'hFFFF_FFFF, 32'h0);
        tick();
        checkOutput("wr_access_penable", 32'(penable), 32'h1);
        checkOutput("wr_access_paddr",   32'(paddr), 32'h10);
        checkOutput("wr_access_pwrite",  32'(pwrite), 32'h1);
        checkOutput("wr_access_pwdata",  pwdata, 32'hA5A5_0001);
        checkOutput("wr_access_done",    32'(done), 32'h0);
        tick();
        checkOutput("wr_done",        32'(done), 32'h1);
        checkOutput("wr_err",         32'(err), 32'h0);
        checkOutput("wr_done_gnt",    32'(gnt), 32'h0);
        checkOutput("wr_done_pselx",  32'(pselx), 32'h0);
        checkOutput("wr_done_rdata",  rdata, 32'h0);
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        tick();
        checkOutput("wr_done_pulse", 32'(done), 32'h0);

        // Read by requester 1 with two wait states.
        applyStimulus(2'b10, 2'b00, 8'h00, 8'h20, 32'h0, 32'h0);
        prdata = 32'hDEAD_BEEF;
        pready = 1'b0;
        tick();
        checkOutput("rd_setup_gnt",    32'(gnt), 32'h2);
        checkOutput("rd_setup_paddr",  32'(paddr), 32'h20);
        checkOutput("rd_setup_pwrite", 32'(pwrite), 32'h0);
        tick();
        checkOutput("rd_access_penable", 32'(penable), 32'h1);
        tick();
        checkOutput("rd_wait1_done",    32'(done), 32'h0);
        checkOutput("rd_wait1_penable", 32'(penable), 32'h1);
        checkOutput("rd_wait1_rdata",   rdata, 32'h0);
        tick();
        checkOutput("rd_wait2_done",    32'(done), 32'h0);
        pready = 1'b1;
        tick();
        checkOutput("rd_done",   32'(done), 32'h2);
        checkOutput("rd_rdata",  rdata, 32'hDEAD_BEEF);
        checkOutput("rd_err",    32'(err), 32'h0);
        checkOutput("rd_penable", 32'(penable), 32'h0);

        // Slave error on a write by requester 0; rdata must hold.
        applyStimulus(2'b01, 2'b01, 8'h30, 8'h00, 32'h0000_0030, 32'h0);
        prdata  = 32'h1234_5678;
        pslverr = 1'b1;
        tick();
        checkOutput("se_setup_gnt", 32'(gnt), 32'h1);
        tick();
        tick();
        checkOutput("se_done",  32'(done), 32'h1);
        checkOutput("se_err",   32'(err), 32'h1);
        checkOutput("se_rdata", rdata, 32'hDEAD_BEEF);
        pslverr = 1'b0;

        // Timeout on a read by requester 1: ACCESS lasts 16 cycles, rdata unchanged.
        applyStimulus(2'b10, 2'b00, 8'h00, 8'h40, 32'h0, 32'h0);
        prdata = 32'hCAFE_F00D;
        pready = 1'b0;
        tick();
        checkOutput("to_setup_gnt", 32'(gnt), 32'h2);
        checkOutput("to_setup_err_cleared_by_next", 32'(done), 32'h0);
        tick();
        for (int c = 0; c < 15; c++) begin
            tick();
            checkOutput("to_wait_done",  32'(done), 32'h0);
            checkOutput("to_wait_pselx", 32'(pselx), 32'h1);
        end
        tick();
        checkOutput("to_done",    32'(done), 32'h2);
        checkOutput("to_err",     32'(err), 32'h1);
        checkOutput("to_rdata",   rdata, 32'hDEAD_BEEF);
        checkOutput("to_pselx",   32'(pselx), 32'h0);
        checkOutput("to_penable", 32'(penable), 32'h0);

        // Requester 0 completes a read, making it the last owner.
        applyStimulus(2'b01, 2'b00, 8'h50, 8'h00, 32'h0, 32'h0);
        prdata = 32'h1111_0000;
        pready = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("pre_done",  32'(done), 32'h1);
        checkOutput("pre_rdata", rdata, 32'h1111_0000);
        checkOutput("pre_err",   32'(err), 32'h0);

        // Requester 1 starts, then reset hits during ACCESS.
        applyStimulus(2'b10, 2'b00, 8'h00, 8'h60, 32'h0, 32'h0);
        pready = 1'b0;
        tick();
        checkOutput("mid_setup_gnt", 32'(gnt), 32'h2);
        tick();
        checkOutput("mid_access_penable", 32'(penable), 32'h1);
        presetn = 1'b0;
        applyStimulus(2'b11, 2'b00, 8'h70, 8'h80, 32'h0, 32'h0);
        prdata = 32'h0000_ABCD;
        pready = 1'b1;
        tick();
        checkOutput("mid_rst_gnt",     32'(gnt), 32'h0);
        checkOutput("mid_rst_done",    32'(done), 32'h0);
        checkOutput("mid_rst_pselx",   32'(pselx), 32'h0);
        checkOutput("mid_rst_penable", 32'(penable), 32'h0);
        checkOutput("mid_rst_rdata",   rdata, 32'h0);
        presetn = 1'b1;

        // Contention: both held, grants alternate starting with requester 0.
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput("cont_gnt",   32'(gnt), (t % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("cont_done0", 32'(done), 32'h0);
            checkOutput("cont_paddr", 32'(paddr), (t % 2 == 0) ? 32'h70 : 32'h80);
            tick();
            checkOutput("cont_penable", 32'(penable), 32'h1);
            tick();
            checkOutput("cont_done",  32'(done), (t % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("cont_err",   32'(err), 32'h0);
            checkOutput("cont_rdata", rdata, 32'h0000_ABCD);
            checkOutput("cont_gnt0",  32'(gnt), 32'h0);
        end
        applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
        tick();
        checkOutput("end_idle_pselx", 32'(pselx), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
